span_raster: RTL
================

// Module: span_raster
// PURPOSE
//  Parametrised horizontal span rasteriser: takes one span (x0, x1, row y, start attribute, per-pixel step) and emits clipped pixels.
//  Emits one pixel per valid/ready handshake, interpolating a fixed-point attribute (depth or shade) along the span.
//  Sits between triangle setup and the framebuffer/z-test stage.
//  Accepts endpoints in either order and clips against [0, FB_WIDTH-1].
// PARAMETERS
//  COORD_WIDTH  16   signed width of x0/x1/y
//  FB_WIDTH     320  framebuffer width; legal x is 0..FB_WIDTH-1
//  ATTR_WIDTH   16   signed attribute/step width, fixed point
//  FRAC_BITS    8    fractional bits of attr0/attr_step/px_attr (format unchanged through the block)
// PORTS
//  clk_in       in   1            system clock
//  rst_in       in   1            asynchronous, active-high reset
//  start_valid  in   1            span request
//  start_ready  out  1            high only in IDLE; span accepted when start_valid && start_ready
//  x0, x1       in   COORD_WIDTH  signed span endpoints, inclusive, any order
//  y_in         in   COORD_WIDTH  row tag, latched and passed through
//  attr0        in   ATTR_WIDTH   signed attribute at x0
//  attr_step    in   ATTR_WIDTH   signed attribute increment per +1 in x
//  px_valid     out  1            pixel available
//  px_ready     in   1            downstream accepts pixel
//  px_x, px_y   out  COORD_WIDTH  pixel coordinates
//  px_attr      out  ATTR_WIDTH   interpolated attribute, saturated
//  px_last      out  1            qualifies the final pixel of the span
//  busy         out  1            span in progress (PREP or DRAW)
//  done         out  1            one-cycle pulse at span completion
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; px_valid, px_last, busy, done = 0; px_x/px_y/px_attr = 0. Span in flight is dropped.
//  xl = max(min(x0,x1),0); xr = min(max(x0,x1),FB_WIDTH-1); compare signed at COORD_WIDTH+1 bits.
//  IDLE: on accept, if min(x0,x1) >= FB_WIDTH or max(x0,x1) < 0, reject.
//    Reject: no pixels; done=1 for one cycle next cycle; stay IDLE.
//    Otherwise latch xl, xr, y_in, attr0, attr_step; busy=1; go to PREP.
//  PREP (1 cycle): acc = sext(attr0) + (xl - x0)*attr_step.
//    Covers both the swap and the left clip.
//    acc width ACC_W = ATTR_WIDTH+COORD_WIDTH+1, signed.
//    Then DRAW with px_valid=1, px_x=xl.
//  DRAW: px_x/px_y/px_attr/px_last held stable while px_valid && !px_ready.
//    On handshake:
//      if px_x==xr: px_valid=0, busy=0, done=1 next cycle, return to IDLE;
//      else px_x+=1, acc+=sext(attr_step).
//  Step direction is always +x; attr_step is the dx-positive gradient regardless of endpoint order.
//  px_attr = acc saturated to [-2^(ATTR_WIDTH-1), 2^(ATTR_WIDTH-1)-1]; acc itself never wraps.
//  px_last = px_valid && (px_x == xr). Single-pixel span (xl==xr): one pixel, px_last=1.
//  Latency: accept at cycle N -> first px_valid at N+2 (N+1 without attr).
//    Throughput 1 pixel/cycle with px_ready held high.
//  start_valid is ignored while busy (start_ready=0). done and start_ready are never high together except in a reject cycle.
// CONFIGURATION
//  SPAN_RASTER_ATTR_EN defined:
//    attribute path and PREP state present, as above.
//  SPAN_RASTER_ATTR_EN not defined:
//    attr0/attr_step unused; px_attr tied to 0.
//    PREP skipped: IDLE goes directly to DRAW, first px_valid at N+1.
//    No multiplier is inferred.
// STRUCTURE
//  span_pkg:
//    typedef enum {IDLE, PREP, DRAW} span_state_t;
//    function sat_attr(acc) for the ACC_W -> ATTR_WIDTH saturating narrow;
//    localparam ACC_W expression.
//  Sub-module span_attr_prep: combinational multiply-add producing acc_start; instantiated only under SPAN_RASTER_ATTR_EN.
// TESTING
//  1 x0=10,x1=13,y=5,attr0=0x0100,step=0x0080, px_ready=1:
//      px_x 10..13, px_attr 0x0100,0x0180,0x0200,0x0280; px_last on x=13; done pulse 1 cycle later.
//  2 x0=13,x1=10, attr0=0x0100, step=0x0080:
//      px_x 10..13 ascending; first px_attr = 0x0100 + (-3*0x0080) = -0x0080.
//  3 x0=-4,x1=2, attr0=0, step=0x0100:
//      px_x 0..2, first px_attr 0x0400; x0=310,x1=400 -> px_x 310..319.
//  4 x0=400,x1=500 and x0=-9,x1=-1:
//      zero px_valid; done pulse next cycle; start_ready stays 1.
//  5 x0=x1=7: one pixel, px_last=1.
//    px_ready toggled randomly on a 20-pixel span: outputs stable while stalled, no pixel lost/duplicated.
//  6 attr0=0x7F00, step=0x0100: px_attr saturates at 0x7FFF.
//    rst_in pulsed mid-DRAW (asynchronously, between clock edges): px_valid/busy drop at once; next span runs cleanly.

Source files
------------

// File: rtl/span_pkg.sv
// Shared span rasteriser types and helpers: FSM states, accumulator width, saturating narrow.
// Purely declarative, no latency and no flow control of its own.
package span_pkg;

  typedef enum logic [1:0] {IDLE, PREP, DRAW} span_state_t;

  localparam int COORD_WIDTH_DEFAULT = 16;
  localparam int ATTR_WIDTH_DEFAULT  = 16;

  // ACC_W = ATTR_WIDTH + COORD_WIDTH + 1: holds attr0 + dx*step without wrapping
  function automatic int acc_w(input int attr_width, input int coord_width);
    return attr_width + coord_width + 1;
  endfunction

  // Clamp a wide signed accumulator into the signed range of an attr_width-bit value
  function automatic logic signed [63:0] sat_attr(input logic signed [63:0] acc,
                                                  input int attr_width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (attr_width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (attr_width - 1));
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/span_attr_prep.sv
// Combinational start value of the attribute accumulator: attr0 + dx*attr_step (zero latency, no flow control).
// Only present when SPAN_RASTER_ATTR_EN is defined; the default build has no multiplier at all.
`ifdef SPAN_RASTER_ATTR_EN
module span_attr_prep #(
  parameter int ATTR_WIDTH  = 16,
  parameter int COORD_WIDTH = 16,
  parameter int ACC_W       = ATTR_WIDTH + COORD_WIDTH + 1
) (
  input  logic signed [ATTR_WIDTH-1:0]  attr0,
  input  logic signed [ATTR_WIDTH-1:0]  attr_step,
  input  logic signed [COORD_WIDTH:0]   dx,
  output logic signed [ACC_W-1:0]       acc_start
);

  logic signed [ACC_W-1:0] attr0_ext;
  logic signed [ACC_W-1:0] step_ext;
  logic signed [ACC_W-1:0] dx_ext;

  assign attr0_ext = {{(ACC_W-ATTR_WIDTH){attr0[ATTR_WIDTH-1]}}, attr0};
  assign step_ext  = {{(ACC_W-ATTR_WIDTH){attr_step[ATTR_WIDTH-1]}}, attr_step};
  assign dx_ext    = {{(ACC_W-COORD_WIDTH-1){dx[COORD_WIDTH]}}, dx};
  assign acc_start = attr0_ext + dx_ext * step_ext;

endmodule
`endif

// File: rtl/span_raster.sv
// Clipped horizontal span rasteriser, one pixel per px_valid/px_ready handshake; first pixel 2 cycles after accept
// with SPAN_RASTER_ATTR_EN (attribute interpolation), 1 cycle without; outputs hold while px_ready is low.
module span_raster
  import span_pkg::*;
#(
  parameter int COORD_WIDTH = COORD_WIDTH_DEFAULT,
  parameter int FB_WIDTH    = 320,
  parameter int ATTR_WIDTH  = ATTR_WIDTH_DEFAULT,
  parameter int FRAC_BITS   = 8
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          start_valid,
  output logic                          start_ready,
  input  logic signed [COORD_WIDTH-1:0] x0,
  input  logic signed [COORD_WIDTH-1:0] x1,
  input  logic [COORD_WIDTH-1:0]        y_in,
  input  logic signed [ATTR_WIDTH-1:0]  attr0,
  input  logic signed [ATTR_WIDTH-1:0]  attr_step,
  output logic                          px_valid,
  input  logic                          px_ready,
  output logic [COORD_WIDTH-1:0]        px_x,
  output logic [COORD_WIDTH-1:0]        px_y,
  output logic signed [ATTR_WIDTH-1:0]  px_attr,
  output logic                          px_last,
  output logic                          busy,
  output logic                          done
);

  localparam int CW    = COORD_WIDTH;
  localparam int EW    = COORD_WIDTH + 1;
  localparam int AW    = ATTR_WIDTH;
  localparam int ACC_W = acc_w(ATTR_WIDTH, COORD_WIDTH);
  localparam logic signed [EW-1:0] X_MAX = EW'(FB_WIDTH - 1);
  // The fixed-point format passes straight through, so the binary point never moves here
  localparam int frac_bits_unused = FRAC_BITS;

  span_state_t state, state_nxt;

  logic signed [EW-1:0] x0_e, x1_e, x_min, x_max, xl_c, xr_c;
  logic                 reject, accept, last_hit, done_draw, done_rej;
  logic [CW-1:0]        xr_q;

  assign x0_e   = {x0[CW-1], x0};
  assign x1_e   = {x1[CW-1], x1};
  assign x_min  = (x0_e < x1_e) ? x0_e : x1_e;
  assign x_max  = (x0_e < x1_e) ? x1_e : x0_e;
  assign reject = (x_min > X_MAX) || x_max[EW-1];
  assign xl_c   = x_min[EW-1] ? '0 : x_min;
  assign xr_c   = (x_max > X_MAX) ? X_MAX : x_max;

  // A finished span keeps start_ready low for its done cycle; a reject does not
  assign start_ready = (state == IDLE) && !done_draw;
  assign accept      = start_valid && start_ready;
  assign last_hit    = (px_x == xr_q);
  assign px_valid    = (state == DRAW);
  assign px_last     = px_valid && last_hit;
  assign busy        = (state != IDLE);
  assign done        = done_draw | done_rej;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && !reject) begin
`ifdef SPAN_RASTER_ATTR_EN
          state_nxt = PREP;
`else
          state_nxt = DRAW;
`endif
        end
      end
      PREP:    state_nxt = DRAW;
      DRAW:    if (px_ready && last_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      px_x      <= '0;
      px_y      <= '0;
      xr_q      <= '0;
      done_draw <= 1'b0;
      done_rej  <= 1'b0;
    end else begin
      done_draw <= 1'b0;
      done_rej  <= 1'b0;
      if (accept) begin
        if (reject) begin
          done_rej <= 1'b1;
        end else begin
          px_x <= xl_c[CW-1:0];
          xr_q <= xr_c[CW-1:0];
          px_y <= y_in;
        end
      end
      if (state == DRAW && px_ready) begin
        if (last_hit) done_draw <= 1'b1;
        else          px_x      <= px_x + CW'(1);
      end
    end
  end

`ifdef SPAN_RASTER_ATTR_EN
  logic signed [EW-1:0]    x0_q, dx;
  logic signed [AW-1:0]    attr0_q, step_q;
  logic signed [ACC_W-1:0] acc, acc_start;
  logic signed [63:0]      acc_wide, attr_wide;
  logic [63-AW:0]          sat_hi_unused;

  // px_x holds xl during PREP, so dx covers both the endpoint swap and the left clip
  assign dx = $signed({1'b0, px_x}) - x0_q;

  span_attr_prep #(
    .ATTR_WIDTH  (AW),
    .COORD_WIDTH (CW),
    .ACC_W       (ACC_W)
  ) u_attr_prep (
    .attr0     (attr0_q),
    .attr_step (step_q),
    .dx        (dx),
    .acc_start (acc_start)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      x0_q    <= '0;
      attr0_q <= '0;
      step_q  <= '0;
      acc     <= '0;
    end else begin
      if (accept && !reject) begin
        x0_q    <= x0_e;
        attr0_q <= attr0;
        step_q  <= attr_step;
      end
      if (state == PREP) acc <= acc_start;
      if (state == DRAW && px_ready && !last_hit)
        acc <= acc + {{(ACC_W-AW){step_q[AW-1]}}, step_q};
    end
  end

  assign acc_wide      = {{(64-ACC_W){acc[ACC_W-1]}}, acc};
  assign attr_wide     = sat_attr(acc_wide, AW);
  assign px_attr       = attr_wide[AW-1:0];
  assign sat_hi_unused = attr_wide[63:AW];
`else
  logic unused_attr;
  assign unused_attr = ^{attr0, attr_step};
  assign px_attr     = '0;
`endif

endmodule
